// File: rtl/ea_sequencer.sv
// Effective-address sequencer: runs the operand/pointer bus reads for the decoded addressing mode.
// Optional EA_STACK_REL_EN enables the stack-relative modes dsp and sriy.
module ea_sequencer #(
    parameter logic [7:0] ZP_PAGE = 8'h00,
    parameter logic [7:0] SP_PAGE = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        ix,
    input  logic        iy,
    input  logic        absy,
    input  logic        zpy,
    input  logic        zi,
    input  logic        dsp,
    input  logic        sriy,
    input  logic        abs,
    input  logic        absx,
    input  logic        zp,
    input  logic        zpx,
    input  logic        imm,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [7:0]  sp,
    input  logic [15:0] pc,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        rd_ack,
    output logic        busy,
    output logic        ea_valid,
    output logic [15:0] ea,
    output logic [1:0]  opnd_len,
    output logic        page_cross,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_OP_LO, S_OP_HI, S_PTR_LO, S_PTR_HI, S_FIX, S_DONE
    } state_t;

    typedef enum logic [3:0] {
        M_IMM, M_ZP, M_ZPX, M_ZPY, M_ABS, M_ABSX, M_ABSY,
        M_IX, M_IY, M_ZI, M_DSP, M_SRIY, M_NONE
    } mode_t;

    state_t      state_q, state_d;
    mode_t       sel_mode, mode_q;
    logic [7:0]  x_q, y_q, lo_q, p_q, ptrlo_q;
    logic [7:0]  lo_d, p_d, ptrlo_d;
    logic [15:0] pc_q;
    logic [15:0] ea_d;
    logic [1:0]  len_d;
    logic        pcx_d, err_d;
    logic [7:0]  idx, zlo, page;
    logic [15:0] base16, sum16;
    logic [8:0]  lo_add;
    logic        carry;

`ifdef EA_STACK_REL_EN
    logic [7:0]  sp_q, slo;
    assign slo = sp_q + rd_data;
`else
    logic unused_stack;
    assign unused_stack = ^{dsp, sriy, sp};
`endif

    always_comb begin
        sel_mode = M_NONE;
        if (imm)       sel_mode = M_IMM;
        else if (zp)   sel_mode = M_ZP;
        else if (zpx)  sel_mode = M_ZPX;
        else if (zpy)  sel_mode = M_ZPY;
        else if (abs)  sel_mode = M_ABS;
        else if (absx) sel_mode = M_ABSX;
        else if (absy) sel_mode = M_ABSY;
        else if (ix)   sel_mode = M_IX;
        else if (iy)   sel_mode = M_IY;
        else if (zi)   sel_mode = M_ZI;
`ifdef EA_STACK_REL_EN
        else if (dsp)  sel_mode = M_DSP;
        else if (sriy) sel_mode = M_SRIY;
`endif
    end

    // X-indexed modes add x; every other indexed mode (including post-indexed pointers) adds y
    assign idx    = (mode_q == M_ZPX || mode_q == M_ABSX || mode_q == M_IX) ? x_q : y_q;
    assign zlo    = rd_data + idx;
    assign base16 = (state_q == S_OP_HI) ? {rd_data, lo_q} : {rd_data, ptrlo_q};
    assign sum16  = base16 + {8'h00, idx};
    assign lo_add = {1'b0, base16[7:0]} + {1'b0, idx};
    assign carry  = lo_add[8];
    assign page   = (mode_q == M_SRIY) ? SP_PAGE : ZP_PAGE;

    always_comb begin
        case (state_q)
            S_OP_LO:  rd_addr = pc_q;
            S_OP_HI:  rd_addr = pc_q + 16'd1;
            S_PTR_LO: rd_addr = {page, p_q};
            S_PTR_HI: rd_addr = {page, p_q + 8'd1};
            default:  rd_addr = 16'h0000;
        endcase
    end

    assign rd_req   = (state_q == S_OP_LO) || (state_q == S_OP_HI) ||
                      (state_q == S_PTR_LO) || (state_q == S_PTR_HI);
    assign busy     = (state_q != S_IDLE);
    assign ea_valid = (state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        ea_d    = ea;
        len_d   = opnd_len;
        pcx_d   = page_cross;
        err_d   = err;
        lo_d    = lo_q;
        p_d     = p_q;
        ptrlo_d = ptrlo_q;
        case (state_q)
            S_IDLE: if (start) begin
                ea_d  = 16'h0000;
                len_d = 2'd0;
                pcx_d = 1'b0;
                err_d = 1'b0;
                if (sel_mode == M_IMM) begin
                    ea_d    = pc;
                    len_d   = 2'd1;
                    state_d = S_DONE;
                end else if (sel_mode == M_NONE) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_OP_LO;
                end
            end
            S_OP_LO: if (rd_ack) begin
                lo_d  = rd_data;
                len_d = 2'd1;
                case (mode_q)
                    M_ZP:                 begin ea_d = {ZP_PAGE, rd_data}; state_d = S_DONE; end
                    M_ZPX, M_ZPY:         begin ea_d = {ZP_PAGE, zlo};     state_d = S_DONE; end
                    M_ABS, M_ABSX, M_ABSY: state_d = S_OP_HI;
                    M_IX:                 begin p_d = zlo;     state_d = S_PTR_LO; end
                    M_IY, M_ZI:           begin p_d = rd_data; state_d = S_PTR_LO; end
`ifdef EA_STACK_REL_EN
                    M_DSP:                begin ea_d = {SP_PAGE, slo};     state_d = S_DONE; end
                    M_SRIY:               begin p_d = slo;     state_d = S_PTR_LO; end
`endif
                    default:              state_d = S_DONE;
                endcase
            end
            S_OP_HI: if (rd_ack) begin
                len_d = 2'd2;
                if (mode_q == M_ABS) begin
                    ea_d    = {rd_data, lo_q};
                    state_d = S_DONE;
                end else begin
                    ea_d    = sum16;
                    pcx_d   = carry;
                    state_d = carry ? S_FIX : S_DONE;
                end
            end
            S_PTR_LO: if (rd_ack) begin
                ptrlo_d = rd_data;
                state_d = S_PTR_HI;
            end
            S_PTR_HI: if (rd_ack) begin
                if (mode_q == M_IY || mode_q == M_SRIY) begin
                    ea_d    = sum16;
                    pcx_d   = carry;
                    state_d = carry ? S_FIX : S_DONE;
                end else begin
                    ea_d    = {rd_data, ptrlo_q};
                    state_d = S_DONE;
                end
            end
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ea         <= 16'h0000;
            opnd_len   <= 2'd0;
            page_cross <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            ea         <= ea_d;
            opnd_len   <= len_d;
            page_cross <= pcx_d;
            err        <= err_d;
        end
    end

    // Operand context is captured once at start; bytes are only meaningful inside a sequence
    always_ff @(posedge clk) begin
        lo_q    <= lo_d;
        p_q     <= p_d;
        ptrlo_q <= ptrlo_d;
        if (state_q == S_IDLE && start) begin
            mode_q <= sel_mode;
            x_q    <= x;
            y_q    <= y;
            pc_q   <= pc;
`ifdef EA_STACK_REL_EN
            sp_q   <= sp;
`endif
        end
    end

endmodule
